// File: rtl/rule_unit_sched.sv
// rule_unit_sched
// Per-packet scheduler placed in front of rule_unit.
//  * Latches one packet header and holds it on ru_src_port/ru_dst_port/ru_tcp.
//  * Merges NUM_LANES candidate-rule streams round-robin into the single rule_unit
//    input, at most one rule per cycle.
//  * Drains the rule_unit pipeline, then pulses out_eop with the packet match count.
// Ports:
//  clk, rst                  clock, asynchronous active-high reset
//  hdr_*                     packet header handshake and fields
//  lane_rule_*               per-lane candidate rule streams (valid/ready/last)
//  ru_*  (out)               header fields and rule stream towards rule_unit
//  ru_match, ru_match_rule   match results coming back from rule_unit
//  out_rule_valid/data       registered match results
//  out_eop, out_match_cnt    end-of-packet pulse with saturating match count
//  busy                      scheduler is working on a packet
module rule_unit_sched #(
    parameter int NUM_LANES   = 4,
    parameter int RULE_AWIDTH = 16,
    parameter int RU_LAT      = 17,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             hdr_valid,
    output logic                             hdr_ready,
    input  logic [15:0]                      hdr_src_port,
    input  logic [15:0]                      hdr_dst_port,
    input  logic                             hdr_tcp,
    input  logic [NUM_LANES*RULE_AWIDTH-1:0] lane_rule_data,
    input  logic [NUM_LANES-1:0]             lane_rule_valid,
    input  logic [NUM_LANES-1:0]             lane_rule_last,
    output logic [NUM_LANES-1:0]             lane_rule_ready,
    output logic [15:0]                      ru_src_port,
    output logic [15:0]                      ru_dst_port,
    output logic                             ru_tcp,
    output logic [RULE_AWIDTH-1:0]           ru_rule_data,
    output logic                             ru_rule_valid,
    input  logic                             ru_match,
    input  logic [RULE_AWIDTH-1:0]           ru_match_rule,
    output logic                             out_rule_valid,
    output logic [RULE_AWIDTH-1:0]           out_rule_data,
    output logic                             out_eop,
    output logic [CNT_WIDTH-1:0]             out_match_cnt,
    output logic                             busy
);

    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int DRN_W = $clog2(RU_LAT + 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_EOP   = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [PTR_W-1:0]        rr_ptr_r;
    logic [NUM_LANES-1:0]    lane_done_r;
    logic [DRN_W-1:0]        drain_cnt_r;
    logic [DRN_W-1:0]        guard_r;
    logic [CNT_WIDTH-1:0]    match_cnt_r;
    logic [15:0]             src_r;
    logic [15:0]             dst_r;
    logic                    tcp_r;
    logic [RULE_AWIDTH-1:0]  ru_data_r;
    logic                    ru_valid_r;
    logic                    out_valid_r;
    logic [RULE_AWIDTH-1:0]  out_data_r;

    logic [NUM_LANES-1:0]    eligible_s;
    logic                    grant_vld_s;
    logic [PTR_W-1:0]        grant_idx_s;
    logic [NUM_LANES-1:0]    lane_ready_s;
    logic [RULE_AWIDTH-1:0]  grant_id_s;
    logic                    grant_last_s;
    logic                    hs_s;
    logic                    hdr_hs_s;
    logic [NUM_LANES-1:0]    done_set_s;
    logic                    all_done_s;

    assign eligible_s   = lane_rule_valid & ~lane_done_r;
    assign hs_s         = (state_r == ST_ISSUE) && grant_vld_s;
    assign hdr_hs_s     = (state_r == ST_IDLE) && hdr_valid;
    assign grant_id_s   = lane_rule_data[int'(grant_idx_s)*RULE_AWIDTH +: RULE_AWIDTH];
    assign grant_last_s = lane_rule_last[grant_idx_s];
    // Lanes finishing this cycle count immediately so DRAIN starts without a bubble.
    assign done_set_s   = lane_done_r | (grant_last_s ? lane_ready_s : {NUM_LANES{1'b0}});
    assign all_done_s   = &done_set_s;

    // Round-robin search: scanning downward leaves the first eligible lane at or after rr_ptr.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = {PTR_W{1'b0}};
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (eligible_s[PTR_W'((int'(rr_ptr_r) + k) % NUM_LANES)]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = PTR_W'((int'(rr_ptr_r) + k) % NUM_LANES);
            end else begin
                grant_vld_s = grant_vld_s;
                grant_idx_s = grant_idx_s;
            end
        end
    end

    // One-hot ready on the granted lane, only while issuing.
    always_comb begin
        lane_ready_s = {NUM_LANES{1'b0}};
        if (hs_s) begin
            lane_ready_s[grant_idx_s] = 1'b1;
        end else begin
            lane_ready_s = {NUM_LANES{1'b0}};
        end
    end

    // Next-state decode of the packet FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = hdr_valid ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nxt_s = all_done_s ? ST_DRAIN : ST_ISSUE;
            ST_DRAIN: state_nxt_s = (drain_cnt_r == DRN_W'(1)) ? ST_EOP : ST_DRAIN;
            ST_EOP:   state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Header latch; fields stay stable for the whole packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_r <= 16'd0;
            dst_r <= 16'd0;
            tcp_r <= 1'b0;
        end else if (hdr_hs_s) begin
            src_r <= hdr_src_port;
            dst_r <= hdr_dst_port;
            tcp_r <= hdr_tcp;
        end else begin
            src_r <= src_r;
            dst_r <= dst_r;
            tcp_r <= tcp_r;
        end
    end

    // Arbitration state: round-robin pointer (kept across packets) and per-lane done flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r    <= {PTR_W{1'b0}};
            lane_done_r <= {NUM_LANES{1'b0}};
        end else if (hdr_hs_s) begin
            rr_ptr_r    <= rr_ptr_r;
            lane_done_r <= {NUM_LANES{1'b0}};
        end else if (hs_s) begin
            rr_ptr_r    <= PTR_W'((int'(grant_idx_s) + 1) % NUM_LANES);
            lane_done_r <= done_set_s;
        end else begin
            rr_ptr_r    <= rr_ptr_r;
            lane_done_r <= lane_done_r;
        end
    end

    // Rule issue register; ID 0 is consumed without reaching rule_unit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ru_valid_r <= 1'b0;
            ru_data_r  <= {RULE_AWIDTH{1'b0}};
        end else if (hs_s && (grant_id_s != {RULE_AWIDTH{1'b0}})) begin
            ru_valid_r <= 1'b1;
            ru_data_r  <= grant_id_s;
        end else begin
            ru_valid_r <= 1'b0;
            ru_data_r  <= {RULE_AWIDTH{1'b0}};
        end
    end

    // Drain counter covers the rule_unit latency after the last issued rule.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt_r <= {DRN_W{1'b0}};
        end else if ((state_r == ST_ISSUE) && all_done_s) begin
            drain_cnt_r <= DRN_W'(RU_LAT + 1);
        end else if (state_r == ST_DRAIN) begin
            drain_cnt_r <= drain_cnt_r - DRN_W'(1);
        end else begin
            drain_cnt_r <= drain_cnt_r;
        end
    end

    // After reset, results from rules issued before the reset may still come back from
    // rule_unit for up to RU_LAT+1 cycles; they are passed through but never counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            guard_r <= DRN_W'(RU_LAT + 1);
        end else if (guard_r != {DRN_W{1'b0}}) begin
            guard_r <= guard_r - DRN_W'(1);
        end else begin
            guard_r <= guard_r;
        end
    end

    // Saturating per-packet match counter, cleared when a new header is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (hdr_hs_s) begin
            match_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (ru_match && (guard_r == {DRN_W{1'b0}}) &&
                     (match_cnt_r != {CNT_WIDTH{1'b1}})) begin
            match_cnt_r <= match_cnt_r + CNT_WIDTH'(1);
        end else begin
            match_cnt_r <= match_cnt_r;
        end
    end

    // Registered match output path, active in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {RULE_AWIDTH{1'b0}};
        end else begin
            out_valid_r <= ru_match;
            out_data_r  <= ru_match ? ru_match_rule : {RULE_AWIDTH{1'b0}};
        end
    end

    assign hdr_ready       = (state_r == ST_IDLE);
    assign busy            = (state_r != ST_IDLE);
    assign out_eop         = (state_r == ST_EOP);
    assign lane_rule_ready = lane_ready_s;
    assign ru_src_port     = src_r;
    assign ru_dst_port     = dst_r;
    assign ru_tcp          = tcp_r;
    assign ru_rule_data    = ru_data_r;
    assign ru_rule_valid   = ru_valid_r;
    assign out_rule_valid  = out_valid_r;
    assign out_rule_data   = out_data_r;
    assign out_match_cnt   = match_cnt_r;

endmodule

// File: tb/tb_rule_unit_sched.sv
// Scoreboard bench for rule_unit_sched with a small rule_unit stand-in: a fixed
// RU_LAT delay line that reports a match for every rule ID whose low nibble is 7.
module tb_rule_unit_sched;

    localparam int NL  = 4;
    localparam int AW  = 16;
    localparam int LAT = 17;
    localparam int CW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              hdr_valid = 1'b0;
    logic              hdr_ready;
    logic [15:0]       hdr_src_port = 16'd0;
    logic [15:0]       hdr_dst_port = 16'd0;
    logic              hdr_tcp = 1'b0;
    logic [NL*AW-1:0]  lane_rule_data;
    logic [NL-1:0]     lane_rule_valid;
    logic [NL-1:0]     lane_rule_last;
    logic [NL-1:0]     lane_rule_ready;
    logic [15:0]       ru_src_port;
    logic [15:0]       ru_dst_port;
    logic              ru_tcp;
    logic [AW-1:0]     ru_rule_data;
    logic              ru_rule_valid;
    logic              ru_match;
    logic [AW-1:0]     ru_match_rule;
    logic              out_rule_valid;
    logic [AW-1:0]     out_rule_data;
    logic              out_eop;
    logic [CW-1:0]     out_match_cnt;
    logic              busy;

    rule_unit_sched #(.NUM_LANES(NL), .RULE_AWIDTH(AW), .RU_LAT(LAT), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .hdr_src_port(hdr_src_port), .hdr_dst_port(hdr_dst_port), .hdr_tcp(hdr_tcp),
        .lane_rule_data(lane_rule_data), .lane_rule_valid(lane_rule_valid),
        .lane_rule_last(lane_rule_last), .lane_rule_ready(lane_rule_ready),
        .ru_src_port(ru_src_port), .ru_dst_port(ru_dst_port), .ru_tcp(ru_tcp),
        .ru_rule_data(ru_rule_data), .ru_rule_valid(ru_rule_valid),
        .ru_match(ru_match), .ru_match_rule(ru_match_rule),
        .out_rule_valid(out_rule_valid), .out_rule_data(out_rule_data),
        .out_eop(out_eop), .out_match_cnt(out_match_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // rule_unit stand-in (not reset by the scheduler reset).
    logic          stub_init = 1'b1;
    logic [AW:0]   pipe [LAT];
    always @(posedge clk) begin
        if (stub_init) begin
            for (int k = 0; k < LAT; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= {ru_rule_valid && (ru_rule_data[3:0] == 4'h7), ru_rule_data};
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
    end
    assign ru_match      = pipe[LAT-1][AW];
    assign ru_match_rule = pipe[LAT-1][AW-1:0];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard queues filled by the stimulus, drained by the monitor.
    logic [AW-1:0] exp_ru  [$];
    logic [AW-1:0] exp_out [$];
    int            exp_eop [$];

    int pkt_ru_cnt = 0, pkt_ru_first = 0, pkt_ru_last = 0;
    int eop_cnt = 0, eop_cyc = 0;
    int last_hs_cyc [NL];

    // Monitor: compares every DUT output event against the queue heads.
    always @(negedge clk) begin
        if (ru_rule_valid) begin
            if (pkt_ru_cnt == 0) pkt_ru_first = cyc;
            pkt_ru_last = cyc;
            pkt_ru_cnt++;
            if (exp_ru.size() == 0) chk("ru_unexpected", ru_rule_data, 32'hFFFF_FFFF);
            else chk("ru_rule_data", ru_rule_data, exp_ru.pop_front());
        end
        if (out_rule_valid) begin
            if (exp_out.size() == 0) chk("out_unexpected", out_rule_data, 32'hFFFF_FFFF);
            else chk("out_rule_data", out_rule_data, exp_out.pop_front());
        end
        if (out_eop) begin
            eop_cyc = cyc;
            eop_cnt++;
            if (exp_eop.size() == 0) chk("eop_unexpected", out_match_cnt, 32'hFFFF_FFFF);
            else chk("out_match_cnt", out_match_cnt, exp_eop.pop_front());
        end
    end

    // Lane sources: per-lane item tables {last, id}.
    logic [AW:0]   lane_tab [NL][8];
    int            lane_len [NL];
    int            lane_pos [NL];
    logic [NL-1:0] lane_en = '1;

    initial begin : lane_drv
        logic [NL-1:0] hs;
        lane_rule_valid = '0;
        lane_rule_last  = '0;
        lane_rule_data  = '0;
        for (int i = 0; i < NL; i++) begin
            lane_len[i] = 0; lane_pos[i] = 0; last_hs_cyc[i] = 0;
        end
        forever begin
            @(negedge clk);
            hs = lane_rule_valid & lane_rule_ready;
            for (int i = 0; i < NL; i++) begin
                if (hs[i]) begin
                    lane_pos[i]++;
                    last_hs_cyc[i] = cyc;
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NL; i++) begin
                if (lane_en[i] && lane_pos[i] < lane_len[i]) begin
                    lane_rule_valid[i]         = 1'b1;
                    lane_rule_last[i]          = lane_tab[i][lane_pos[i]][AW];
                    lane_rule_data[i*AW +: AW] = lane_tab[i][lane_pos[i]][AW-1:0];
                end else begin
                    lane_rule_valid[i]         = 1'b0;
                    lane_rule_last[i]          = 1'b0;
                    lane_rule_data[i*AW +: AW] = '0;
                end
            end
        end
    end

    task automatic put(input int ln, input logic last, input logic [AW-1:0] id);
        lane_tab[ln][lane_len[ln]] = {last, id};
        lane_len[ln]++;
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < NL; i++) begin
            lane_len[i] = 0; lane_pos[i] = 0;
        end
        pkt_ru_cnt = 0;
    endtask

    task automatic send_hdr(input logic [15:0] s, input logic [15:0] d, input logic t);
        int n;
        @(posedge clk); #1;
        hdr_valid = 1'b1; hdr_src_port = s; hdr_dst_port = d; hdr_tcp = t;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (hdr_ready) break;
        end
        if (n == 100) chk("hdr_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        hdr_valid = 1'b0;
    endtask

    task automatic wait_eop();
        int start;
        int n;
        start = eop_cnt;
        for (n = 0; n < 500; n++) begin
            @(posedge clk);
            if (eop_cnt != start) break;
        end
        if (n == 500) chk("eop_timeout", 32'd0, 32'd1);
    endtask

    initial begin : main
        int maxhs;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; stub_init = 1'b0;
        @(negedge clk);
        chk("rst_hdr_ready", hdr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ru_valid", ru_rule_valid, 0);
        chk("rst_eop", out_eop, 0);
        chk("rst_cnt", out_match_cnt, 0);
        chk("rst_src", ru_src_port, 0);

        // 1: lane0 IDs 5,7; rule 7 matches.
        clear_lanes();
        put(0, 1'b0, 16'd5); put(0, 1'b1, 16'd7);
        for (int i = 1; i < NL; i++) put(i, 1'b1, 16'd0);
        exp_ru.push_back(16'd5); exp_ru.push_back(16'd7);
        exp_out.push_back(16'd7); exp_eop.push_back(1);
        send_hdr(16'd80, 16'd443, 1'b1);
        @(negedge clk);
        chk("t1_busy", busy, 1);
        chk("t1_hdr_ready", hdr_ready, 0);
        chk("t1_src", ru_src_port, 80);
        chk("t1_dst", ru_dst_port, 443);
        chk("t1_tcp", ru_tcp, 1);
        wait_eop();
        chk("t1_ru_cnt", pkt_ru_cnt, 2);
        @(negedge clk);
        chk("t1_idle", busy, 0);

        // 3: only ID 0 everywhere.
        clear_lanes();
        for (int i = 0; i < NL; i++) put(i, 1'b1, 16'd0);
        exp_eop.push_back(0);
        send_hdr(16'd1, 16'd2, 1'b0);
        wait_eop();
        maxhs = 0;
        for (int i = 0; i < NL; i++) if (last_hs_cyc[i] > maxhs) maxhs = last_hs_cyc[i];
        chk("t3_ru_cnt", pkt_ru_cnt, 0);
        chk("t3_eop_lat", eop_cyc - maxhs, LAT + 2);

        // 5: reset while ISSUE waits on empty lanes.
        clear_lanes();
        send_hdr(16'd3, 16'd4, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t5_busy_before", busy, 1);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_hdr_ready", hdr_ready, 1);
        chk("t5_src", ru_src_port, 0);
        chk("t5_tcp", ru_tcp, 0);
        @(posedge clk); #1 rst = 1'b0;

        // 2: 4 lanes x 3 IDs, continuous; rr_ptr restarts at 0.
        clear_lanes();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NL; i++) begin
                logic [AW-1:0] id;
                id = 16'h2001 | AW'(i << 8) | AW'(k << 4);
                if (i == 1 && k == 1) id = 16'h2117;
                put(i, (k == 2), id);
                exp_ru.push_back(id);
            end
        end
        exp_out.push_back(16'h2117); exp_eop.push_back(1);
        send_hdr(16'd5, 16'd6, 1'b0);
        wait_eop();
        chk("t2_ru_cnt", pkt_ru_cnt, 12);
        chk("t2_no_bubble", pkt_ru_last - pkt_ru_first, 11);

        // 4: lane2 withheld for 50 cycles.
        clear_lanes();
        lane_en = 4'b1011;
        put(0, 1'b1, 16'h0005); put(1, 1'b1, 16'd0); put(3, 1'b1, 16'd0);
        put(2, 1'b1, 16'h0027);
        exp_ru.push_back(16'h0005); exp_ru.push_back(16'h0027);
        exp_out.push_back(16'h0027); exp_eop.push_back(1);
        send_hdr(16'd7, 16'd8, 1'b1);
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("t4_busy", busy, 1);
        chk("t4_ready", lane_rule_ready, 0);
        @(posedge clk); #1 lane_en = '1;
        wait_eop();
        chk("t4_eop_lat", eop_cyc - last_hs_cyc[2], LAT + 2);

        // 6: five matches saturate a 2-bit counter at 3.
        clear_lanes();
        put(0, 1'b0, 16'h0017); put(0, 1'b0, 16'h0027); put(0, 1'b0, 16'h0037);
        put(0, 1'b0, 16'h0047); put(0, 1'b1, 16'h0057);
        for (int i = 1; i < NL; i++) put(i, 1'b1, 16'd0);
        for (int k = 1; k <= 5; k++) begin
            exp_ru.push_back(AW'(k * 16 + 7));
            exp_out.push_back(AW'(k * 16 + 7));
        end
        exp_eop.push_back(3);
        send_hdr(16'd9, 16'd10, 1'b0);
        wait_eop();
        repeat (3) @(posedge clk);

        chk("left_ru", exp_ru.size(), 0);
        chk("left_out", exp_out.size(), 0);
        chk("left_eop", exp_eop.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
